// File: rtl/prio_encoder_ack.sv
// ============================================================================
// Module      : prio_encoder_ack
// Description : Edge-captured priority encoder with acknowledge. Rising edges
//               on the request lines set sticky pending bits; the winning
//               pending index is presented on y together with group-select
//               (gs) and a cascade enable-out (eout). An ack taken while gs=1
//               retires the presented index, and the next winner appears on
//               the same registered edge.
//
//               Compile-time option:
//                 PRIO_ROTATE_EN  undefined : fixed priority, highest index wins
//                 PRIO_ROTATE_EN  defined   : rotating priority. A W-bit pointer
//                                             p records the last acknowledged
//                                             index. The search runs downward
//                                             from (p-1) mod N, wraps, and
//                                             ends at p.
//
// Ports       : clk   in   sole clock, rising edge
//               rst   in   asynchronous active-high reset
//               ein   in   enable-in. When low, all outputs read inactive
//                          while capture continues.
//               req   in   [N-1:0] level request lines; a rising edge is an event
//               ack   in   acknowledge, honoured only while gs=1 and ein=1
//               y     out  [W-1:0] registered winning index (0 when gs=0)
//               gs    out  registered group-select
//               eout  out  registered enable-out (ein=1 and nothing pending)
//
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prio_encoder_ack #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ein,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         gs,
  output logic         eout
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N-1:0] req_d_q,   req_d_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q,       y_d;
  logic         gs_q,      gs_d;
  logic         eout_q,    eout_d;

  // --------------------------------------------------------------------------
  // Event capture and retirement
  // --------------------------------------------------------------------------
  logic [N-1:0] rise;
  logic [N-1:0] clr_mask;
  logic         accept;

  always_comb begin
    rise     = req & ~req_d_q;
    // gs_q can only be 1 if ein was high on the previous edge. ein is
    // re-checked here because ein=0 freezes pending against clears.
    accept   = ack & gs_q & ein;
    clr_mask = '0;
    if (accept) begin
      clr_mask[y_q] = 1'b1;
    end
    req_d_d   = req;
    // The set term is OR-ed in last, so a simultaneous rise overrides the clear.
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  // --------------------------------------------------------------------------
  // Winner selection on the next-state pending vector
  // --------------------------------------------------------------------------
  logic [W-1:0] win;

`ifdef PRIO_ROTATE_EN
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] sel;
  logic         found;

  // The pointer advances on the same edge that retires the index, so the
  // search for the next winner already uses the updated pointer.
  always_comb begin
    p_d = accept ? y_q : p_q;
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N; k++) begin
      sel = W'((int'(p_d) + N - k) % N);
      if (!found && pending_d[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end
`else
  // Ascending scan: each later (higher) set bit overwrites any earlier match.
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_d[i]) begin
        win = W'(i);
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Output next-state
  // --------------------------------------------------------------------------
  logic any_pending;

  always_comb begin
    any_pending = |pending_d;
    gs_d        = ein & any_pending;
    eout_d      = ein & ~any_pending;
    y_d         = gs_d ? win : '0;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d_q   <= '0;
      pending_q <= '0;
      y_q       <= '0;
      gs_q      <= 1'b0;
      eout_q    <= 1'b0;
    end else begin
      req_d_q   <= req_d_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      gs_q      <= gs_d;
      eout_q    <= eout_d;
    end
  end

  assign y    = y_q;
  assign gs   = gs_q;
  assign eout = eout_q;

endmodule

`default_nettype wire
